// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped instruction cache with a line-fill FSM between the PC and
// backing instruction memory; a miss stalls fetch and returns a NOP.
module icache_fetch_ctrl #(
   parameter int unsigned LINES    = 8,
   parameter int unsigned WORDS    = 4,
   parameter logic [31:0] NOP_WORD = 32'hFC000000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] PC,
   input  logic        inv,
   output logic [31:0] Instruction,
   output logic        iMemError,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_valid,
   output logic [15:0] miss_count
);

   localparam int OW = $clog2(WORDS);
   localparam int IW = $clog2(LINES);
   localparam int TL = 2 + OW + IW;
   localparam int TW = 32 - TL;

   typedef enum logic {IDLE, FILL} state_t;

   state_t           state;
   logic [LINES-1:0] valid_q;
   logic [TW-1:0]    tag_q [LINES];
   logic [31:0]      data_q [LINES*WORDS];
   logic [IW-1:0]    fill_index;
   logic [TW-1:0]    fill_tag;
   logic [OW-1:0]    beat;
   logic             discard;

   logic [OW-1:0]    offset;
   logic [IW-1:0]    index;
   logic [TW-1:0]    tag;
   logic             hit;
   logic             last_beat;
   logic             unused_pc;

   assign offset    = PC[TL-IW-1:2];
   assign index     = PC[TL-1:TL-IW];
   assign tag       = PC[31:TL];
   assign unused_pc = ^PC[1:0];

   assign hit = (state == IDLE) && valid_q[index] && (tag_q[index] == tag);
   assign last_beat = (state == FILL) && mem_valid &&
                      (beat == OW'(WORDS - 1));

   assign Instruction = hit ? data_q[{index, offset}] : NOP_WORD;
   assign iMemError   = ~hit;

   // Arrays carry no reset; only valid_q qualifies their contents.
   always_ff @(posedge Clk) begin
      if (!Rst && state == FILL && mem_valid)
         data_q[{fill_index, beat}] <= mem_rdata;
      if (!Rst && last_beat)
         tag_q[fill_index] <= fill_tag;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= IDLE;
         valid_q    <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         beat       <= '0;
         miss_count <= '0;
         discard    <= 1'b0;
         fill_index <= '0;
         fill_tag   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (inv) begin
                  valid_q <= '0;
               end else if (!hit) begin
                  fill_index     <= index;
                  fill_tag       <= tag;
                  mem_addr       <= {PC[31:OW+2], {(OW+2){1'b0}}};
                  valid_q[index] <= 1'b0;
                  beat           <= '0;
                  mem_req        <= 1'b1;
                  if (miss_count != 16'hFFFF)
                     miss_count <= miss_count + 16'd1;
                  state <= FILL;
               end
            end
            FILL: begin
               if (mem_valid)
                  beat <= beat + 1'b1;
               if (inv)
                  discard <= 1'b1;
               if (last_beat) begin
                  mem_req <= 1'b0;
                  discard <= 1'b0;
                  state   <= IDLE;
                  if (!discard && !inv)
                     valid_q[fill_index] <= 1'b1;
               end
               // An invalidate always wins over the line being validated.
               if (inv)
                  valid_q <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench for icache_fetch_ctrl: fills, hits, eviction,
// invalidate, reset mid-fill and miss counter saturation.
module tb_icache_fetch_ctrl;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] PC;
   logic        inv;
   logic [31:0] Instruction;
   logic        iMemError;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic [15:0] miss_count;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0]  NOP = 32'hFC000000;
   localparam logic [127:0] LA  = {32'hAC030000, 32'h00221820,
                                   32'h20020003, 32'h20010005};
   localparam logic [127:0] LB  = {32'h44444444, 32'h33333333,
                                   32'h22222222, 32'h11111111};
   localparam logic [127:0] LC  = {32'hC0DE0003, 32'hC0DE0002,
                                   32'hC0DE0001, 32'hC0DE0000};

   icache_fetch_ctrl dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .PC          (PC),
      .inv         (inv),
      .Instruction (Instruction),
      .iMemError   (iMemError),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_valid   (mem_valid),
      .miss_count  (miss_count)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Entered just after the edge that raised mem_req.
   task automatic fill(input string tag, input logic [31:0] base,
                       input logic [127:0] w, input int gap,
                       input int inv_at);
      chk({tag, " req"}, 32'(mem_req), 32'd1);
      chk({tag, " addr"}, mem_addr, base);
      repeat (gap) begin
         #1;
         chk({tag, " gap err"}, 32'(iMemError), 32'd1);
         chk({tag, " gap nop"}, Instruction, NOP);
         step();
      end
      for (int i = 0; i < 4; i++) begin
         mem_valid = 1'b1;
         mem_rdata = w[32*i +: 32];
         inv       = (i == inv_at);
         #1;
         chk({tag, " beat err"}, 32'(iMemError), 32'd1);
         chk({tag, " beat nop"}, Instruction, NOP);
         chk({tag, " beat req"}, 32'(mem_req), 32'd1);
         step();
      end
      mem_valid = 1'b0;
      mem_rdata = '0;
      inv       = 1'b0;
      chk({tag, " req drop"}, 32'(mem_req), 32'd0);
   endtask

   initial begin
      Rst       = 1'b1;
      inv       = 1'b0;
      mem_valid = 1'b0;
      mem_rdata = '0;
      PC        = 32'h0;
      step();
      step();
      chk("rst req", 32'(mem_req), 32'd0);
      chk("rst addr", mem_addr, 32'h0);
      chk("rst cnt", 32'(miss_count), 32'd0);
      chk("rst err", 32'(iMemError), 32'd1);
      chk("rst instr", Instruction, NOP);

      Rst = 1'b0;
      step();
      chk("cold cnt", 32'(miss_count), 32'd1);
      fill("cold", 32'h0, LA, 1, -1);
      #1;
      chk("cold hit err", 32'(iMemError), 32'd0);
      chk("cold hit instr", Instruction, 32'h20010005);
      chk("cold cnt2", 32'(miss_count), 32'd1);

      for (int i = 1; i < 4; i++) begin
         PC = 32'(4 * i);
         #1;
         chk("seq instr", Instruction, LA[32*i +: 32]);
         chk("seq err", 32'(iMemError), 32'd0);
         chk("seq req", 32'(mem_req), 32'd0);
         step();
      end

      PC = 32'h80;
      #1;
      chk("evict miss", 32'(iMemError), 32'd1);
      step();
      chk("evict cnt", 32'(miss_count), 32'd2);
      chk("evict v0", 32'(dut.valid_q[0]), 32'd0);
      fill("evict", 32'h80, LB, 0, -1);
      #1;
      chk("evict hit", Instruction, 32'h11111111);
      chk("evict hit err", 32'(iMemError), 32'd0);
      PC = 32'h0;
      #1;
      chk("remiss err", 32'(iMemError), 32'd1);
      step();
      chk("remiss cnt", 32'(miss_count), 32'd3);
      fill("refill", 32'h0, LA, 0, -1);
      #1;
      chk("refill hit", Instruction, 32'h20010005);

      PC = 32'h10;
      #1;
      step();
      chk("inv cnt", 32'(miss_count), 32'd4);
      fill("inv", 32'h10, LC, 0, 1);
      #1;
      chk("inv relookup", 32'(iMemError), 32'd1);
      chk("inv valid", 32'(dut.valid_q), 32'd0);
      step();
      chk("inv refill cnt", 32'(miss_count), 32'd5);
      fill("inv refill", 32'h10, LC, 0, -1);
      #1;
      chk("inv refill hit", Instruction, 32'hC0DE0000);
      chk("inv refill err", 32'(iMemError), 32'd0);
      PC = 32'h1C;
      #1;
      chk("inv refill w3", Instruction, 32'hC0DE0003);

      PC = 32'h20;
      #1;
      step();
      fill("inv last", 32'h20, LB, 0, 3);
      #1;
      chk("inv last valid", 32'(dut.valid_q), 32'd0);
      chk("inv last cnt", 32'(miss_count), 32'd6);

      PC = 32'h30;
      #1;
      step();
      chk("rmid cnt", 32'(miss_count), 32'd7);
      for (int i = 0; i < 2; i++) begin
         mem_valid = 1'b1;
         mem_rdata = LA[32*i +: 32];
         step();
      end
      mem_valid = 1'b0;
      Rst       = 1'b1;
      step();
      chk("rmid req", 32'(mem_req), 32'd0);
      chk("rmid cnt0", 32'(miss_count), 32'd0);
      chk("rmid valid", 32'(dut.valid_q), 32'd0);
      Rst       = 1'b0;
      inv       = 1'b1;
      mem_valid = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      step();
      step();
      chk("stray err", 32'(iMemError), 32'd1);
      chk("stray instr", Instruction, NOP);
      chk("stray req", 32'(mem_req), 32'd0);
      chk("stray cnt", 32'(miss_count), 32'd0);
      mem_valid = 1'b0;
      inv       = 1'b0;

      force dut.miss_count = 16'hFFFE;
      #1;
      release dut.miss_count;
      step();
      chk("sat cnt1", 32'(miss_count), 32'h0000FFFF);
      fill("sat1", 32'h30, LA, 0, -1);
      PC = 32'hB0;
      #1;
      step();
      chk("sat cnt2", 32'(miss_count), 32'h0000FFFF);
      fill("sat2", 32'hB0, LB, 0, -1);
      #1;
      chk("sat hit", Instruction, 32'h11111111);
      chk("sat cnt3", 32'(miss_count), 32'h0000FFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
